// File: rtl/integrator_mc.sv
// integrator_mc: sample-driven recursive integrator with programmable 3-tap
// coefficients and selectable feedback distance (y[n-1] or y[n-2]).
// Result is clipped to the output range and a sticky flag records any clip.
module integrator_mc #(
    parameter int DATA_W    = 22,
    parameter int IN_FRAC   = 10,
    parameter int COEF_W    = 11,
    parameter int COEF_FRAC = 10,
    parameter int ACC_W     = 34
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic        [COEF_W-1:0] c0,
    input  logic        [COEF_W-1:0] c1,
    input  logic        [COEF_W-1:0] c2,
    input  logic                     fb_sel,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     sat
);

    // Products carry IN_FRAC+COEF_FRAC fraction bits; the feedback term is
    // already in output format, so the alignment shift is normally zero.
    localparam int OUT_FRAC  = IN_FRAC + COEF_FRAC;
    localparam int PROD_FRAC = IN_FRAC + COEF_FRAC;
    localparam int ALIGN     = PROD_FRAC - OUT_FRAC;

    // Sum width never drops below what three full-scale products plus the
    // feedback term need, so the adder tree cannot wrap before clipping.
    localparam int MIN_W = DATA_W + COEF_W + 3;
    localparam int SUM_W = (ACC_W > MIN_W) ? ACC_W : MIN_W;

    localparam logic signed [SUM_W-1:0] SUM_MAX =
        {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN =
        {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] x1, x2, y1, y2;

    logic signed [SUM_W-1:0] x0_e, x1_e, x2_e;
    logic signed [SUM_W-1:0] c0_e, c1_e, c2_e;
    logic signed [SUM_W-1:0] fb_e, y_sum;
    logic signed [DATA_W-1:0] y_sat;
    logic                     y_clip;

    // Recursion sum at full precision followed by clipping to the output range.
    always_comb begin
        x0_e   = SUM_W'(in_data);
        x1_e   = SUM_W'(x1);
        x2_e   = SUM_W'(x2);
        // Coefficients are unsigned: zero-extend before the signed multiply.
        c0_e   = SUM_W'({1'b0, c0});
        c1_e   = SUM_W'({1'b0, c1});
        c2_e   = SUM_W'({1'b0, c2});
        fb_e   = SUM_W'(fb_sel ? y2 : y1) <<< ALIGN;
        y_sum  = x0_e * c0_e + x1_e * c1_e + x2_e * c2_e + fb_e;
        y_sat  = y_sum[DATA_W-1:0];
        y_clip = 1'b0;
        if (y_sum > SUM_MAX) begin
            y_sat  = OUT_MAX;
            y_clip = 1'b1;
        end else if (y_sum < SUM_MIN) begin
            y_sat  = OUT_MIN;
            y_clip = 1'b1;
        end
    end

    // History, output and sticky flag; reset beats clear beats a new sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                x1       <= in_data;
                x2       <= x1;
                y1       <= y_sat;
                y2       <= y1;
                out_data <= y_sat;
                if (y_clip)
                    sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_integrator_mc.sv
// Directed bench for integrator_mc: a vector table for the rule presets and
// hand-written sequences for mid-stream reset/clear and feedback switching.
module tb_integrator_mc;

    localparam int DATA_W = 22;
    localparam int COEF_W = 11;

    logic                     clk = 1'b0;
    logic                     reset, clear, in_valid, fb_sel;
    logic signed [DATA_W-1:0] in_data;
    logic        [COEF_W-1:0] c0, c1, c2;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     sat;

    integrator_mc dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .c0       (c0),
        .c1       (c1),
        .c2       (c2),
        .fb_sel   (fb_sel),
        .out_valid(out_valid),
        .out_data (out_data),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit clr;
        bit v;
        int d;
        int a, b, c;
        bit fb;
        bit ev;
        int ed;
        bit es;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    // Golden-model state for the feedback-switch sequence
    longint m_x1, m_x2, m_y1, m_y2;

    function automatic vec_t mk(bit rst, bit clr, bit v, int d, int a, int b, int c,
                                bit fb, bit ev, int ed, bit es);
        vec_t t;
        t.rst = rst; t.clr = clr; t.v = v; t.d = d;
        t.a = a; t.b = b; t.c = c; t.fb = fb;
        t.ev = ev; t.ed = ed; t.es = es;
        return t;
    endfunction

    // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic drive(input bit rst, input bit clr, input bit v, input int d,
                         input int a, input int b, input int c, input bit fb);
        reset    = rst;
        clear    = clr;
        in_valid = v;
        in_data  = DATA_W'(d);
        c0       = COEF_W'(a);
        c1       = COEF_W'(b);
        c2       = COEF_W'(c);
        fb_sel   = fb;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input bit ev, input int ed, input bit es);
        int got;
        got = out_data;
        checks++;
        if (out_valid !== ev) begin
            errors++;
            $display("FAIL %s out_valid got %0b expected %0b", name, out_valid, ev);
        end
        checks++;
        if (got != ed) begin
            errors++;
            $display("FAIL %s out_data got %0d expected %0d", name, got, ed);
        end
        checks++;
        if (sat !== es) begin
            errors++;
            $display("FAIL %s sat got %0b expected %0b", name, sat, es);
        end
    endtask

    task automatic model_reset();
        m_x1 = 0; m_x2 = 0; m_y1 = 0; m_y2 = 0;
    endtask

    task automatic model_step(input longint x, input longint a, input longint b,
                              input longint c, input bit fb, output int y);
        longint s;
        s = a * x + b * m_x1 + c * m_x2 + (fb ? m_y2 : m_y1);
        if (s > 2097151) s = 2097151;
        if (s < -2097152) s = -2097152;
        m_x2 = m_x1; m_x1 = x;
        m_y2 = m_y1; m_y1 = s;
        y = int'(s);
    endtask

    initial begin
        int y;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        c0 = '0; c1 = '0; c2 = '0; fb_sel = 1'b0;

        // rst clr v data c0 c1 c2 fb | exp valid data sat
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,       0,0,0));
        // Simpson, 0.25 every cycle
        vecs.push_back(mk(0,0,1,256,  367,1314,367,1, 1,93952,0));
        vecs.push_back(mk(0,0,1,256,  367,1314,367,1, 1,430336,0));
        vecs.push_back(mk(0,0,1,256,  367,1314,367,1, 1,618240,0));
        vecs.push_back(mk(0,0,1,256,  367,1314,367,1, 1,954624,0));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,       0,0,0));
        // Simpson, 1.0 every cycle: clips on the third sample
        vecs.push_back(mk(0,0,1,1024, 367,1314,367,1, 1,375808,0));
        vecs.push_back(mk(0,0,1,1024, 367,1314,367,1, 1,1721344,0));
        vecs.push_back(mk(0,0,1,1024, 367,1314,367,1, 1,2097151,1));
        vecs.push_back(mk(0,0,1,1024, 367,1314,367,1, 1,2097151,1));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,       0,0,0));
        // Rectangular, -0.5: lands exactly on the minimum, then clips
        vecs.push_back(mk(0,0,1,-512, 1024,0,0,0,    1,-524288,0));
        vecs.push_back(mk(0,0,1,-512, 1024,0,0,0,    1,-1048576,0));
        vecs.push_back(mk(0,0,1,-512, 1024,0,0,0,    1,-1572864,0));
        vecs.push_back(mk(0,0,1,-512, 1024,0,0,0,    1,-2097152,0));
        vecs.push_back(mk(0,0,1,-512, 1024,0,0,0,    1,-2097152,1));
        vecs.push_back(mk(1,0,0,0,    0,0,0,0,       0,0,0));
        // Trapezoidal with gaps: 1,0,0,1,1 then idle
        vecs.push_back(mk(0,0,1,1024, 512,512,0,0,   1,524288,0));
        vecs.push_back(mk(0,0,0,1024, 512,512,0,0,   0,524288,0));
        vecs.push_back(mk(0,0,0,1024, 512,512,0,0,   0,524288,0));
        vecs.push_back(mk(0,0,1,1024, 512,512,0,0,   1,1572864,0));
        vecs.push_back(mk(0,0,1,1024, 512,512,0,0,   1,2097151,1));
        vecs.push_back(mk(0,0,0,1024, 512,512,0,0,   0,2097151,1));
        // Clear with a simultaneous sample: sample dropped, sat cleared
        vecs.push_back(mk(0,1,1,1024, 512,512,0,0,   0,0,0));
        vecs.push_back(mk(0,0,0,1024, 512,512,0,0,   0,0,0));
        vecs.push_back(mk(0,0,1,1024, 512,512,0,0,   1,524288,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].v, vecs[i].d,
                  vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].fb);
            chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].es);
        end

        // Mid-stream reset on the third sample cycle, then restart
        drive(1,0,0,0,   0,0,0,0);
        drive(0,0,1,256, 367,1314,367,1); chk("rst_s0", 1, 93952, 0);
        drive(0,0,1,256, 367,1314,367,1); chk("rst_s1", 1, 430336, 0);
        drive(1,0,1,256, 367,1314,367,1); chk("rst_mid", 0, 0, 0);
        drive(0,0,1,256, 367,1314,367,1); chk("rst_r0", 1, 93952, 0);
        drive(0,0,1,256, 367,1314,367,1); chk("rst_r1", 1, 430336, 0);

        // Same with clear (sample in the clear cycle is dropped)
        drive(0,1,1,256, 367,1314,367,1); chk("clr_mid", 0, 0, 0);
        drive(0,0,0,256, 367,1314,367,1); chk("clr_idle", 0, 0, 0);
        drive(0,0,1,256, 367,1314,367,1); chk("clr_r0", 1, 93952, 0);
        drive(0,0,1,256, 367,1314,367,1); chk("clr_r1", 1, 430336, 0);
        drive(0,0,1,256, 367,1314,367,1); chk("clr_r2", 1, 618240, 0);

        // Feedback distance switched mid-stream, against the golden model
        drive(1,0,0,0, 0,0,0,0);
        model_reset();
        model_step(256, 1024, 0, 0, 0, y);
        drive(0,0,1,256, 1024,0,0,0); chk("fb0_s0", 1, y, 0);
        model_step(256, 1024, 0, 0, 0, y);
        drive(0,0,1,256, 1024,0,0,0); chk("fb0_s1", 1, y, 0);
        drive(0,0,0,256, 1024,0,0,1); chk("fb_gap", 0, y, 0);
        model_step(256, 1024, 0, 0, 1, y);
        drive(0,0,1,256, 1024,0,0,1); chk("fb1_s2", 1, y, 0);
        model_step(256, 1024, 0, 0, 1, y);
        drive(0,0,1,256, 1024,0,0,1); chk("fb1_s3", 1, y, 0);
        model_step(-300, 1024, 0, 0, 0, y);
        drive(0,0,1,-300, 1024,0,0,0); chk("fb0_s4", 1, y, 0);
        drive(0,0,0,0,   1024,0,0,0); chk("fb_end", 0, y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
